// File: rtl/tid_mask_collector.sv
// Thread-completion collector: captures an expected thread set, accumulates
// reported thread indices, and presents the collected set once complete.
module tid_mask_collector #(
  parameter int MASK_W = 64,
  parameter int TID_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start_valid,
  input  logic [MASK_W-1:0] start_mask,
  output logic              start_ready,
  input  logic              tid_valid,
  input  logic [TID_W-1:0]  tid,
  output logic              tid_ready,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [MASK_W-1:0] done_mask,
  output logic [TID_W:0]    done_count,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [TID_W:0]    MASK_W_L = (TID_W + 1)'(MASK_W);
  localparam logic [MASK_W-1:0] ONE_L    = {{(MASK_W - 1){1'b0}}, 1'b1};
  localparam logic [MASK_W-1:0] ZERO_L   = {MASK_W{1'b0}};

  state_e              state_q, state_d;
  logic [MASK_W-1:0]   expected_q, expected_d;
  logic [MASK_W-1:0]   collected_q, collected_d;
  logic [TID_W:0]      count_q, count_d;
  logic                err_q, err_d;

  logic                tid_in_range_s;
  logic [MASK_W-1:0]   tid_onehot_s;
  logic                tid_new_s;
  logic [MASK_W-1:0]   collected_upd_s;

  // Handshake readiness is a pure decode of the current state.
  always_comb begin
    start_ready = 1'b0;
    tid_ready   = 1'b0;
    done_valid  = 1'b0;
    case (state_q)
      ST_IDLE:    start_ready = 1'b1;
      ST_COLLECT: tid_ready   = 1'b1;
      ST_DONE:    done_valid  = 1'b1;
      default:    start_ready = 1'b0;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign done_mask  = collected_q;
  assign done_count = count_q;
  assign err        = err_q;

  // Out-of-range indices decode to an all-zero one-hot and are never "new".
  always_comb begin
    tid_in_range_s  = ({1'b0, tid} < MASK_W_L);
    tid_onehot_s    = ONE_L << tid;
    tid_new_s       = tid_in_range_s && ((tid_onehot_s & expected_q & ~collected_q) != ZERO_L);
    collected_upd_s = collected_q | tid_onehot_s;
  end

  // Next-state logic; flush overrides every handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    collected_d = collected_q;
    count_d     = count_q;
    err_d       = 1'b0;
    if (flush) begin
      state_d     = ST_IDLE;
      expected_d  = ZERO_L;
      collected_d = ZERO_L;
      count_d     = {(TID_W + 1){1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            expected_d  = start_mask;
            collected_d = ZERO_L;
            count_d     = {(TID_W + 1){1'b0}};
            if (start_mask == ZERO_L) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_COLLECT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (tid_valid) begin
            if (tid_new_s) begin
              collected_d = collected_upd_s;
              if (count_q != MASK_W_L) begin
                count_d = count_q + {{TID_W{1'b0}}, 1'b1};
              end else begin
                count_d = count_q;
              end
              if (collected_upd_s == expected_q) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_COLLECT;
              end
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      expected_q  <= ZERO_L;
      collected_q <= ZERO_L;
      count_q     <= {(TID_W + 1){1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      collected_q <= collected_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_tid_mask_collector.sv
// Directed, table-driven bench for tid_mask_collector with hand sequences
// for the full-mask collection and asynchronous reset cases.
module tb_tid_mask_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        start_valid = 1'b0;
  logic [63:0] start_mask = 64'd0;
  logic        start_ready;
  logic        tid_valid = 1'b0;
  logic [5:0]  tid = 6'd0;
  logic        tid_ready;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [63:0] done_mask;
  logic [6:0]  done_count;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  tid_mask_collector #(.MASK_W(64), .TID_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .start_valid(start_valid), .start_mask(start_mask), .start_ready(start_ready),
    .tid_valid(tid_valid), .tid(tid), .tid_ready(tid_ready),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_mask(done_mask), .done_count(done_count),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        fl;
    logic        sv;
    logic [63:0] sm;
    logic        tv;
    logic [5:0]  t;
    logic        dr;
    logic        e_sr;
    logic        e_tr;
    logic        e_dv;
    logic        e_busy;
    logic        e_err;
    logic [6:0]  e_cnt;
    logic [63:0] e_mask;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(string name, logic fl, logic sv, logic [63:0] sm,
                               logic tv, logic [5:0] t, logic dr,
                               logic [2:0] st, logic e_err, logic [6:0] e_cnt,
                               logic [63:0] e_mask);
    vec_t v;
    v.name = name; v.fl = fl; v.sv = sv; v.sm = sm; v.tv = tv; v.t = t; v.dr = dr;
    // st is {idle, collect, done}
    v.e_sr = st[2]; v.e_tr = st[1]; v.e_dv = st[0];
    v.e_busy = ~st[2]; v.e_err = e_err; v.e_cnt = e_cnt; v.e_mask = e_mask;
    return v;
  endfunction

  task automatic drive(logic fl, logic sv, logic [63:0] sm, logic tv, logic [5:0] t, logic dr);
    flush = fl; start_valid = sv; start_mask = sm; tid_valid = tv; tid = t; done_ready = dr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic e_sr, logic e_tr, logic e_dv, logic e_busy,
                     logic e_err, logic [6:0] e_cnt, logic [63:0] e_mask);
    logic [75:0] act, exp_v;
    act   = {start_ready, tid_ready, done_valid, busy, err, done_count, done_mask};
    exp_v = {e_sr, e_tr, e_dv, e_busy, e_err, e_cnt, e_mask};
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got sr/tr/dv/busy/err=%b%b%b%b%b cnt=%0d mask=%h, want %b%b%b%b%b cnt=%0d mask=%h",
               name, start_ready, tid_ready, done_valid, busy, err, done_count, done_mask,
               e_sr, e_tr, e_dv, e_busy, e_err, e_cnt, e_mask);
    end
  endtask

  localparam logic [2:0] I = 3'b100;
  localparam logic [2:0] C = 3'b010;
  localparam logic [2:0] D = 3'b001;

  initial begin
    // back-to-back tids 2 then 0 on mask 0x5
    vecs.push_back(mkv("m5_start", 0, 1, 64'h5, 0, 6'd0, 0, C, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("m5_tid2",  0, 0, 64'h0, 1, 6'd2, 0, C, 0, 7'd1, 64'h4));
    vecs.push_back(mkv("m5_tid0",  0, 0, 64'h0, 1, 6'd0, 0, D, 0, 7'd2, 64'h5));
    vecs.push_back(mkv("m5_ack",   0, 0, 64'h0, 0, 6'd0, 1, I, 0, 7'd2, 64'h5));
    // unexpected tid errors, duplicate arrives in DONE and is ignored
    vecs.push_back(mkv("m1_start", 0, 1, 64'h1, 0, 6'd0, 0, C, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("m1_tid5",  0, 0, 64'h0, 1, 6'd5, 0, C, 1, 7'd0, 64'h0));
    vecs.push_back(mkv("m1_tid0",  0, 0, 64'h0, 1, 6'd0, 0, D, 0, 7'd1, 64'h1));
    vecs.push_back(mkv("m1_dup",   0, 0, 64'h0, 1, 6'd0, 0, D, 0, 7'd1, 64'h1));
    vecs.push_back(mkv("m1_ack",   0, 0, 64'h0, 0, 6'd0, 1, I, 0, 7'd1, 64'h1));
    // empty mask goes straight to DONE
    vecs.push_back(mkv("m0_start", 0, 1, 64'h0, 1, 6'd0, 0, D, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("m0_hold",  0, 0, 64'h0, 1, 6'd0, 0, D, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("m0_ack",   0, 0, 64'h0, 0, 6'd0, 1, I, 0, 7'd0, 64'h0));
    // flush beats a same-cycle tid; next collection starts from zero
    vecs.push_back(mkv("f0_start", 0, 1, 64'hF0, 0, 6'd0, 0, C, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("f0_tid4",  0, 0, 64'h0, 1, 6'd4, 0, C, 0, 7'd1, 64'h10));
    vecs.push_back(mkv("f0_tid5",  0, 0, 64'h0, 1, 6'd5, 0, C, 0, 7'd2, 64'h30));
    vecs.push_back(mkv("f0_flush", 1, 0, 64'h0, 1, 6'd6, 0, I, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("f1_start", 0, 1, 64'h40, 0, 6'd0, 0, C, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("f1_tid6",  0, 0, 64'h0, 1, 6'd6, 0, D, 0, 7'd1, 64'h40));
    vecs.push_back(mkv("f1_flushd",1, 0, 64'h0, 0, 6'd0, 1, I, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("f_idle_st",1, 1, 64'h3, 0, 6'd0, 0, I, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("idle_ign", 0, 0, 64'h0, 1, 6'd0, 1, I, 0, 7'd0, 64'h0));
    // repeated tid errors without changing count
    vecs.push_back(mkv("d_start",  0, 1, 64'h3, 0, 6'd0, 0, C, 0, 7'd0, 64'h0));
    vecs.push_back(mkv("d_tid0",   0, 0, 64'h0, 1, 6'd0, 0, C, 0, 7'd1, 64'h1));
    vecs.push_back(mkv("d_tid0x",  0, 0, 64'h0, 1, 6'd0, 0, C, 1, 7'd1, 64'h1));
    vecs.push_back(mkv("d_idle",   0, 0, 64'h0, 0, 6'd0, 0, C, 0, 7'd1, 64'h1));
    vecs.push_back(mkv("d_tid1",   0, 0, 64'h0, 1, 6'd1, 0, D, 0, 7'd2, 64'h3));
    vecs.push_back(mkv("d_ack",    0, 0, 64'h0, 0, 6'd0, 1, I, 0, 7'd2, 64'h3));

    #2;
    chk("reset_state", 1, 0, 0, 0, 0, 7'd0, 64'h0);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fl, vecs[i].sv, vecs[i].sm, vecs[i].tv, vecs[i].t, vecs[i].dr);
      step();
      chk(vecs[i].name, vecs[i].e_sr, vecs[i].e_tr, vecs[i].e_dv, vecs[i].e_busy,
          vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_mask);
    end

    // full mask, tids 63 down to 0, then done held for three cycles
    begin
      logic [63:0] acc;
      acc = 64'd0;
      drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 6'd0, 0);
      step();
      chk("full_start", 0, 1, 0, 1, 0, 7'd0, 64'h0);
      for (int k = 63; k >= 0; k--) begin
        drive(0, 0, 64'h0, 1, 6'(k), 0);
        step();
        acc[k] = 1'b1;
        if (k == 0) chk("full_last", 0, 0, 1, 1, 0, 7'd64, acc);
        else        chk("full_tid",  0, 1, 0, 1, 0, 7'(64 - k), acc);
      end
      drive(0, 0, 64'h0, 0, 6'd0, 0);
      for (int h = 0; h < 3; h++) begin
        step();
        chk("full_hold", 0, 0, 1, 1, 0, 7'd64, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      drive(0, 0, 64'h0, 0, 6'd0, 1);
      step();
      chk("full_ack", 1, 0, 0, 0, 0, 7'd64, 64'hFFFF_FFFF_FFFF_FFFF);
    end

    // asynchronous reset in the middle of a collection
    drive(0, 1, 64'hF0, 0, 6'd0, 0);
    step();
    chk("ar_start", 0, 1, 0, 1, 0, 7'd0, 64'h0);
    drive(0, 0, 64'h0, 1, 6'd4, 0);
    step();
    chk("ar_tid4", 0, 1, 0, 1, 0, 7'd1, 64'h10);
    drive(0, 0, 64'h0, 0, 6'd0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async", 1, 0, 0, 0, 0, 7'd0, 64'h0);
    #2;
    rst_n = 1'b1;
    drive(0, 1, 64'h2, 0, 6'd0, 0);
    step();
    chk("ar_restart", 0, 1, 0, 1, 0, 7'd0, 64'h0);
    drive(0, 0, 64'h0, 1, 6'd1, 0);
    step();
    chk("ar_tid1", 0, 0, 1, 1, 0, 7'd1, 64'h2);
    drive(0, 0, 64'h0, 0, 6'd0, 1);
    step();
    chk("ar_ack", 1, 0, 0, 0, 0, 7'd1, 64'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tid_mask_collector.md
TID_MASK_COLLECTOR -- requirements
Module: tid_mask_collector

Interface
REQ-001 SHALL have parameter MASK_W, default 64, thread-mask width.
REQ-002 SHALL have parameter TID_W, default 6, thread-index width (log2 MASK_W).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort; returns to IDLE.
REQ-006 SHALL have port start_valid  input  1  new collection request.
REQ-007 SHALL have port start_mask  input  MASK_W  expected thread set.
REQ-008 SHALL have port start_ready  output  1  request acceptable.
REQ-009 SHALL have port tid_valid  input  1  a thread reports completion.
REQ-010 SHALL have port tid  input  TID_W  index of the completing thread.
REQ-011 SHALL have port tid_ready  output  1  tid acceptable.
REQ-012 SHALL have port done_valid  output  1  collection complete.
REQ-013 SHALL have port done_ready  input  1  consumer accepts done.
REQ-014 SHALL have port done_mask  output  MASK_W  collected thread set.
REQ-015 SHALL have port done_count  output  TID_W+1  popcount of done_mask (0..MASK_W).
REQ-016 SHALL have port busy  output  1  high in COLLECT or DONE.
REQ-017 SHALL have port err  output  1  one-cycle pulse: rejected tid.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, DONE; start_ready=1 only in IDLE, tid_ready=1 only in COLLECT, done_valid=1 only in DONE; all three outputs decoded combinationally from state.
REQ-019 IDLE: on start_valid&start_ready SHALL capture expected=start_mask, clear collected and count; next state COLLECT, or DONE if start_mask==0.
REQ-020 Start latency: start handshake in cycle N -> tid_ready=1 in N+1 (or done_valid=1 in N+1 for an empty mask).
REQ-021 COLLECT: a tid handshake SHALL decode tid to one-hot; if the bit is set in expected and clear in collected, set it in collected and increment count.
REQ-022 A tid whose bit is clear in expected, already set in collected, or whose value is >= MASK_W SHALL leave collected/count unchanged and pulse err in the following cycle.
REQ-023 When an accepted tid makes collected==expected, next state SHALL be DONE; done_valid rises in the cycle after the final tid handshake.
REQ-024 DONE: done_mask=collected, done_count=count, both held stable while done_valid=1 and done_ready=0.
REQ-025 DONE: on done_ready=1, next state SHALL be IDLE; collected/count remain visible until the next start.
REQ-026 done_ready is ignored outside DONE; tid_valid is ignored outside COLLECT, with no err.
REQ-027 flush=1 in any state SHALL force IDLE next cycle, clear collected/count/expected, and suppress err; flush wins over a same-cycle start, tid or done handshake.
REQ-028 done_count SHALL never exceed MASK_W; no count wrap.
REQ-029 busy SHALL equal (state!=IDLE).

Reset
REQ-030 rst_n=0 SHALL immediately set state=IDLE and expected/collected=0, count=0, err=0; outputs become start_ready=1, tid_ready=0, done_valid=0, done_mask=0, done_count=0, busy=0.
REQ-031 Reset asserted mid-collection SHALL discard partial state; the first post-reset start behaves as from power-up.

Verification
REQ-032 start_mask=0x0000_0000_0000_0005, tids 2 then 0 back-to-back -> done_valid in cycle after tid 0, done_mask=0x5, done_count=2, err never high.
REQ-033 start_mask=0xFFFF_FFFF_FFFF_FFFF, tids 63..0 one per cycle, done_ready held low for 3 cycles -> done_count=64, done_mask all-ones, stable for 3 cycles, IDLE after done_ready.
REQ-034 start_mask=0x1, tid 5 then tid 0 then tid 0 again -> err pulses once after tid 5, count=1, then DONE; the duplicate falls outside COLLECT (tid_ready=0), no err.
REQ-035 start_mask=0x0 -> done_valid the cycle after the start handshake, done_count=0, tid_ready never asserted.
REQ-036 start_mask=0xF0, tids 4,5 accepted, then flush together with tid 6 -> IDLE next cycle, tid 6 not recorded, err=0, next start begins with count=0.
REQ-037 rst_n pulsed low asynchronously mid-COLLECT -> outputs match REQ-030 before the next clk edge; a subsequent start_mask=0x2 with tid 1 completes with done_count=1.
